// File: rtl/alu_pkg.sv
// Shared ALU control encodings, ALUOp/funct keys and issue FSM states.
// Imported by the decoder and the issue stage.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0111;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  localparam logic [1:0] OP_LS = 2'b00;
  localparam logic [1:0] OP_BR = 2'b01;
  localparam logic [1:0] OP_R  = 2'b10;
  localparam logic [1:0] OP_I  = 2'b11;

  localparam logic [9:0] F_ADD = 10'b0000000_000;
  localparam logic [9:0] F_SUB = 10'b0100000_000;
  localparam logic [9:0] F_MUL = 10'b0000001_000;
  localparam logic [9:0] F_AND = 10'b0000000_111;
  localparam logic [9:0] F_OR  = 10'b0000000_110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MWAIT = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       is_mul;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_op_issue_if.sv
// ID -> issue -> ALU handshake bundle.
// master drives beats and ready_i; slave is the issue stage.
interface alu_op_issue_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       ALUOp_i;
  logic [9:0]       funct_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             valid_o;
  logic             ready_i;
  logic [3:0]       ALUCtrl_o;
  logic [WIDTH-1:0] data1_o;
  logic [WIDTH-1:0] data2_o;
  logic             illegal_o;

  modport master (
    output valid_i, ALUOp_i, funct_i,
    output data1_i, data2_i, ready_i,
    input  ready_o, valid_o, ALUCtrl_o,
    input  data1_o, data2_o, illegal_o
  );

  modport slave (
    input  valid_i, ALUOp_i, funct_i,
    input  data1_i, data2_i, ready_i,
    output ready_o, valid_o, ALUCtrl_o,
    output data1_o, data2_o, illegal_o
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct -> ALU control code, MUL flag, illegal flag.
// Illegal patterns fall back to add so the beat still flows.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [9:0] i_funct,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '{ctrl: ALU_ADD, is_mul: 1'b0, illegal: 1'b0};
    unique case (i_aluop)
      OP_LS: o_dec.ctrl = ALU_ADD;
      OP_BR: o_dec.ctrl = ALU_SUB;
      OP_I:  o_dec.illegal = (i_funct[2:0] != 3'b000);
      OP_R: begin
        unique case (i_funct)
          F_ADD: o_dec.ctrl = ALU_ADD;
          F_SUB: o_dec.ctrl = ALU_SUB;
          F_AND: o_dec.ctrl = ALU_AND;
          F_OR:  o_dec.ctrl = ALU_OR;
          F_MUL: begin
            o_dec.ctrl   = ALU_MUL;
            o_dec.is_mul = 1'b1;
          end
          default: o_dec.illegal = 1'b1;
        endcase
      end
      default: o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// One-entry issue slot between ID and the ALU.
// MUL beats are held back MUL_LAT-1 extra cycles before valid_o.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int WIDTH   = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_op_issue_if.slave bus
);

  localparam int CW = $clog2(MUL_LAT) + 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(MUL_LAT - 1);

  state_e           r_state;
  state_e           w_next;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_ctrl;
  logic             r_ill;
  logic [WIDTH-1:0] r_d1;
  logic [WIDTH-1:0] r_d2;
  dec_t             w_dec;
  logic             w_ready;
  logic             w_acc;
  logic             w_to_wait;

  alu_ctrl_decode u_dec (
    .i_aluop (bus.ALUOp_i),
    .i_funct (bus.funct_i),
    .o_dec   (w_dec)
  );

  // ready_o only sees state and ready_i, never valid_i
  assign w_ready = (r_state == S_IDLE) |
                   ((r_state == S_FULL) & bus.ready_i);
  assign w_acc     = bus.valid_i & w_ready;
  assign w_to_wait = w_dec.is_mul & (MUL_LAT > 1);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc)
          w_next = w_to_wait ? S_MWAIT : S_FULL;
      end
      S_MWAIT: begin
        if (r_cnt == CW'(1))
          w_next = S_FULL;
      end
      S_FULL: begin
        if (bus.ready_i) begin
          if (!w_acc)         w_next = S_IDLE;
          else if (w_to_wait) w_next = S_MWAIT;
          else                w_next = S_FULL;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ctrl  <= ALU_ADD;
      r_ill   <= 1'b0;
      r_d1    <= '0;
      r_d2    <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_ctrl <= w_dec.ctrl;
        r_ill  <= w_dec.illegal;
        r_d1   <= bus.data1_i;
        r_d2   <= bus.data2_i;
        r_cnt  <= w_dec.is_mul ? LAT_M1 : '0;
      end else if (r_state == S_MWAIT) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign bus.ready_o   = w_ready;
  assign bus.valid_o   = (r_state == S_FULL);
  assign bus.ALUCtrl_o = r_ctrl;
  assign bus.illegal_o = r_ill;
  assign bus.data1_o   = r_d1;
  assign bus.data2_o   = r_d2;

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: decode table, corner sequences,
// and a randomized run against a slot-timing reference model.
module tb_alu_op_issue;

  localparam int MLAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_issue_if #(.WIDTH(32)) bus ();

  alu_op_issue #(.MUL_LAT(MLAT), .WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] op;
    logic [9:0] fn;
    logic [3:0] ctrl;
    logic       ill;
    int         lat;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] op, input logic [9:0] fn,
                      input logic [31:0] a, input logic [31:0] b);
    bus.valid_i = 1'b1;
    bus.ALUOp_i = op;
    bus.funct_i = fn;
    bus.data1_i = a;
    bus.data2_i = b;
  endtask

  // returns {ctrl[3:0], illegal, is_mul}
  function automatic logic [5:0] ref_dec(input logic [1:0] op,
                                         input logic [9:0] fn);
    logic [5:0] r;
    r = {4'b0010, 1'b0, 1'b0};
    if (op == 2'd1) r = {4'b0110, 2'b00};
    else if (op == 2'd3 && fn[2:0] != 3'd0) r = {4'b0010, 2'b10};
    else if (op == 2'd2) begin
      if      (fn == 10'h000) r = {4'b0010, 2'b00};
      else if (fn == 10'h100) r = {4'b0110, 2'b00};
      else if (fn == 10'h008) r = {4'b0111, 2'b01};
      else if (fn == 10'h007) r = {4'b0000, 2'b00};
      else if (fn == 10'h006) r = {4'b0001, 2'b00};
      else                    r = {4'b0010, 2'b10};
    end
    return r;
  endfunction

  logic [9:0] fpool[8];

  initial begin
    logic [31:0] a, b;
    int          n;

    vt[0]  = '{2'b00, 10'h3ff, 4'b0010, 1'b0, 1};
    vt[1]  = '{2'b01, 10'h155, 4'b0110, 1'b0, 1};
    vt[2]  = '{2'b11, 10'h2a8, 4'b0010, 1'b0, 1};
    vt[3]  = '{2'b11, 10'h005, 4'b0010, 1'b1, 1};
    vt[4]  = '{2'b10, 10'h000, 4'b0010, 1'b0, 1};
    vt[5]  = '{2'b10, 10'h100, 4'b0110, 1'b0, 1};
    vt[6]  = '{2'b10, 10'h008, 4'b0111, 1'b0, MLAT};
    vt[7]  = '{2'b10, 10'h007, 4'b0000, 1'b0, 1};
    vt[8]  = '{2'b10, 10'h006, 4'b0001, 1'b0, 1};
    vt[9]  = '{2'b10, 10'h107, 4'b0010, 1'b1, 1};
    vt[10] = '{2'b10, 10'h009, 4'b0010, 1'b1, 1};
    vt[11] = '{2'b10, 10'h001, 4'b0010, 1'b1, 1};

    fpool = '{10'h000, 10'h100, 10'h008, 10'h007,
              10'h006, 10'h107, 10'h008, 10'h001};

    // reset with valid_i asserted
    beat(2'b10, 10'h000, 32'hdead, 32'hbeef);
    bus.ready_i = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_ctrl", bus.ALUCtrl_o, 4'b0010);
    chk("rst_d1", bus.data1_o, 0);
    chk("rst_d2", bus.data2_o, 0);
    chk("rst_ill", bus.illegal_o, 0);
    chk("rst_ready", bus.ready_o, 1);
    rst = 1'b0;
    bus.valid_i = 1'b0;
    tick();

    // R-type add
    beat(2'b10, 10'h000, 5, 7);
    tick();
    bus.valid_i = 1'b0;
    chk("add_valid", bus.valid_o, 1);
    chk("add_ctrl", bus.ALUCtrl_o, 4'b0010);
    chk("add_d1", bus.data1_o, 5);
    chk("add_d2", bus.data2_o, 7);
    tick();
    chk("add_drain", bus.valid_o, 0);

    // decode table, latency measured per vector
    foreach (vt[i]) begin
      a = $urandom;
      b = $urandom;
      beat(vt[i].op, vt[i].fn, a, b);
      tick();
      bus.valid_i = 1'b0;
      n = 1;
      while (!bus.valid_o && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("tbl%0d_lat", i), n, vt[i].lat);
      chk($sformatf("tbl%0d_ctrl", i), bus.ALUCtrl_o, vt[i].ctrl);
      chk($sformatf("tbl%0d_ill", i), bus.illegal_o, vt[i].ill);
      chk($sformatf("tbl%0d_d1", i), bus.data1_o, a);
      chk($sformatf("tbl%0d_d2", i), bus.data2_o, b);
      tick();
    end

    // MUL: two wait cycles with ready_o low
    beat(2'b10, 10'h008, 3, 4);
    tick();
    bus.valid_i = 1'b0;
    chk("mul_w1_rdy", bus.ready_o, 0);
    chk("mul_w1_v", bus.valid_o, 0);
    tick();
    chk("mul_w2_rdy", bus.ready_o, 0);
    chk("mul_w2_v", bus.valid_o, 0);
    tick();
    chk("mul_v", bus.valid_o, 1);
    chk("mul_ctrl", bus.ALUCtrl_o, 4'b0111);
    chk("mul_rdy", bus.ready_o, 1);
    tick();

    // backpressure on a sub beat, queued and-beat
    bus.ready_i = 1'b0;
    beat(2'b01, 10'h000, 32'h11, 32'h22);
    tick();
    beat(2'b10, 10'h007, 32'h33, 32'h44);
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", bus.valid_o, 1);
      chk("bp_ctrl", bus.ALUCtrl_o, 4'b0110);
      chk("bp_d1", bus.data1_o, 32'h11);
      chk("bp_rdy", bus.ready_o, 0);
      tick();
    end
    bus.ready_i = 1'b1;
    #1;
    chk("bp_release_rdy", bus.ready_o, 1);
    tick();
    bus.valid_i = 1'b0;
    chk("bp_and_v", bus.valid_o, 1);
    chk("bp_and_ctrl", bus.ALUCtrl_o, 4'b0000);
    chk("bp_and_d1", bus.data1_o, 32'h33);
    tick();

    // back-to-back stream
    beat(2'b10, 10'h000, 1, 1);
    tick();
    beat(2'b10, 10'h006, 2, 2);
    chk("s0_ctrl", bus.ALUCtrl_o, 4'b0010);
    chk("s0_v", bus.valid_o, 1);
    tick();
    beat(2'b10, 10'h007, 3, 3);
    chk("s1_ctrl", bus.ALUCtrl_o, 4'b0001);
    chk("s1_v", bus.valid_o, 1);
    tick();
    bus.valid_i = 1'b0;
    chk("s2_ctrl", bus.ALUCtrl_o, 4'b0000);
    chk("s2_v", bus.valid_o, 1);
    tick();
    chk("s_drain", bus.valid_o, 0);

    // illegal R-type
    beat(2'b10, 10'h107, 9, 9);
    tick();
    bus.valid_i = 1'b0;
    chk("ill_v", bus.valid_o, 1);
    chk("ill_ctrl", bus.ALUCtrl_o, 4'b0010);
    chk("ill_flag", bus.illegal_o, 1);
    tick();

    // reset during MWAIT drops the MUL
    beat(2'b10, 10'h008, 77, 88);
    tick();
    bus.valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rstw_v", bus.valid_o, 0);
      tick();
    end
    chk("rstw_d1", bus.data1_o, 0);
    chk("rstw_ctrl", bus.ALUCtrl_o, 4'b0010);

    // randomized run against slot-timing model
    begin
      bit          occ;
      int          cyc, rdy_at;
      logic [3:0]  m_ctrl;
      logic        m_ill;
      logic [31:0] m_d1, m_d2;
      logic [5:0]  rd;
      bit          vis, exp_rdy, acc;
      occ = 0;
      cyc = 0;
      rdy_at = 0;
      m_ctrl = 4'b0010;
      m_ill = 0;
      m_d1 = 0;
      m_d2 = 0;
      for (int c = 0; c < 400; c++) begin
        bus.valid_i = ($urandom_range(0, 3) != 0);
        bus.ALUOp_i = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0)
          bus.funct_i = 10'($urandom);
        else
          bus.funct_i = fpool[$urandom_range(0, 7)];
        bus.data1_i = $urandom;
        bus.data2_i = $urandom;
        bus.ready_i = ($urandom_range(0, 9) < 7);
        #1;
        vis = occ && (cyc >= rdy_at);
        exp_rdy = !occ || (vis && bus.ready_i);
        chk("rnd_ready", bus.ready_o, exp_rdy);
        chk("rnd_valid", bus.valid_o, vis);
        if (vis) begin
          chk("rnd_ctrl", bus.ALUCtrl_o, m_ctrl);
          chk("rnd_ill", bus.illegal_o, m_ill);
          chk("rnd_d1", bus.data1_o, m_d1);
          chk("rnd_d2", bus.data2_o, m_d2);
        end
        acc = bus.valid_i && exp_rdy;
        rd = ref_dec(bus.ALUOp_i, bus.funct_i);
        a = bus.data1_i;
        b = bus.data2_i;
        @(posedge clk);
        cyc++;
        if (vis && bus.ready_i) occ = 0;
        if (acc) begin
          occ = 1;
          rdy_at = cyc + (rd[0] ? MLAT - 1 : 0);
          m_ctrl = rd[5:2];
          m_ill = rd[1];
          m_d1 = a;
          m_d2 = b;
        end
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
